// File: rtl/conv2_row_feeder.sv
// Double-buffered-free row feeder: stores a 2-channel frame, then streams one row per slot to the conv stage.
// Optional top/bottom zero-pad slots are enabled by defining ROW_ZERO_PAD_EN.
module conv2_row_feeder #(
  parameter int SLOT_LEN = 26,
  parameter int ROWS     = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic         wr_ch,
  input  logic [3:0]   wr_row,
  input  logic [223:0] wr_data,
  input  logic         start,
  input  logic         hold,
  output logic [223:0] out_ch1,
  output logic [223:0] out_ch2,
  output logic [4:0]   slot_cnt,
  output logic [4:0]   row_idx,
  output logic         row_valid,
  output logic         busy,
  output logic         done,
  output logic         wr_err,
  output logic [2:0]   fsm_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PAD_TOP = 3'd1,
    STREAM  = 3'd2,
    PAD_BOT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [4:0] LAST_SLOT = 5'(SLOT_LEN - 1);
  localparam logic [3:0] LAST_ROW  = 4'(ROWS - 1);
  localparam logic [4:0] ROWS_W    = 5'(ROWS);

  state_t       state;
  logic [3:0]   data_row;
  logic [223:0] buf_ch1 [ROWS];
  logic [223:0] buf_ch2 [ROWS];
  logic         wr_ok;
  logic         wr_bad;
  logic         start_ok;
  logic         slot_end;

  assign wr_ok     = wr_en && !busy && ({1'b0, wr_row} < ROWS_W);
  assign wr_bad    = wr_en && !wr_ok;
  assign start_ok  = (state == IDLE) && start;
  assign slot_end  = (slot_cnt == LAST_SLOT);
  assign fsm_state = state;

  // Frame storage is deliberately not reset so an aborted frame can be replayed.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_ch) buf_ch2[wr_row] <= wr_data;
      else       buf_ch1[wr_row] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      data_row  <= '0;
      out_ch1   <= '0;
      out_ch2   <= '0;
      slot_cnt  <= '0;
      row_idx   <= '0;
      row_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_bad)        wr_err <= 1'b1;
      else if (start_ok) wr_err <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            row_valid <= 1'b1;
            slot_cnt  <= '0;
            row_idx   <= '0;
            data_row  <= '0;
`ifdef ROW_ZERO_PAD_EN
            state     <= PAD_TOP;
`else
            state     <= STREAM;
            out_ch1   <= buf_ch1[4'd0];
            out_ch2   <= buf_ch2[4'd0];
`endif
          end
        end

        PAD_TOP: begin
          if (!hold) begin
            if (slot_end) begin
              slot_cnt <= '0;
              row_idx  <= row_idx + 5'd1;
              state    <= STREAM;
              out_ch1  <= buf_ch1[4'd0];
              out_ch2  <= buf_ch2[4'd0];
            end else begin
              slot_cnt <= slot_cnt + 5'd1;
            end
          end
        end

        STREAM: begin
          if (!hold) begin
            if (!slot_end) begin
              slot_cnt <= slot_cnt + 5'd1;
            end else begin
              slot_cnt <= '0;
              if (data_row == LAST_ROW) begin
                out_ch1 <= '0;
                out_ch2 <= '0;
`ifdef ROW_ZERO_PAD_EN
                row_idx   <= row_idx + 5'd1;
                state     <= PAD_BOT;
`else
                row_idx   <= '0;
                state     <= DONE;
                busy      <= 1'b0;
                row_valid <= 1'b0;
                done      <= 1'b1;
`endif
              end else begin
                // Next row is loaded on the wrap edge so it lines up with slot_cnt == 0.
                row_idx  <= row_idx + 5'd1;
                data_row <= data_row + 4'd1;
                out_ch1  <= buf_ch1[data_row + 4'd1];
                out_ch2  <= buf_ch2[data_row + 4'd1];
              end
            end
          end
        end

        PAD_BOT: begin
          if (!hold) begin
            if (slot_end) begin
              slot_cnt  <= '0;
              row_idx   <= '0;
              state     <= DONE;
              busy      <= 1'b0;
              row_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              slot_cnt <= slot_cnt + 5'd1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv2_row_feeder.sv
// Bench for conv2_row_feeder: frame streaming, hold, write errors, restarts and mid-frame reset.
// Expected rows come from a per-slot queue built from the stored-frame model.
module tb_conv2_row_feeder;

  localparam int SLOT_LEN = 26;
  localparam int ROWS     = 14;
`ifdef ROW_ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int FRAME_SLOTS = ROWS + 2 * PAD;
  localparam int FRAME_CYC   = SLOT_LEN * FRAME_SLOTS;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         wr_en = 1'b0;
  logic         wr_ch = 1'b0;
  logic [3:0]   wr_row = '0;
  logic [223:0] wr_data = '0;
  logic         start = 1'b0;
  logic         hold = 1'b0;
  logic [223:0] out_ch1;
  logic [223:0] out_ch2;
  logic [4:0]   slot_cnt;
  logic [4:0]   row_idx;
  logic         row_valid;
  logic         busy;
  logic         done;
  logic         wr_err;
  logic [2:0]   fsm_state;

  conv2_row_feeder #(.SLOT_LEN(SLOT_LEN), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_row(wr_row),
    .wr_data(wr_data), .start(start), .hold(hold), .out_ch1(out_ch1),
    .out_ch2(out_ch2), .slot_cnt(slot_cnt), .row_idx(row_idx),
    .row_valid(row_valid), .busy(busy), .done(done), .wr_err(wr_err),
    .fsm_state(fsm_state)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [223:0] ref_ch1 [ROWS];
  logic [223:0] ref_ch2 [ROWS];
  logic [447:0] exp_q[$];
  bit exp_wr_err = 1'b0;

  function automatic logic [223:0] rand224();
    logic [223:0] v;
    for (int i = 0; i < 7; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // driver tasks
  task automatic write_row(input bit ch, input int row, input logic [223:0] data);
    wr_en = 1'b1; wr_ch = ch; wr_row = 4'(row); wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (row < ROWS) begin
      if (ch) ref_ch2[row] = data;
      else    ref_ch1[row] = data;
    end else begin
      exp_wr_err = 1'b1;
    end
  endtask

  // Streams one frame, checking every cycle against the slot queue.
  // hold_mode: 0 none, 1 hold_len cycles at hold_u, 2 random.
  task automatic run_frame(input int hold_mode, input int hold_u, input int hold_len,
                           input int restart_u, input bit start_in_done,
                           input int bad_wr_u, input int abort_u);
    int u;
    int held;
    bit h;
    bit new_slot;
    bit fired_restart;
    bit fired_bad;
    logic [447:0] cur;
    exp_q.delete();
    for (int s = 0; s < FRAME_SLOTS; s++) begin
      if (s < PAD || s >= PAD + ROWS) exp_q.push_back('0);
      else exp_q.push_back({ref_ch2[s-PAD], ref_ch1[s-PAD]});
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_wr_err = 1'b0;
    u = 0; held = 0; new_slot = 1'b1; fired_restart = 1'b0; fired_bad = 1'b0; cur = '0;
    while (u < FRAME_CYC) begin
      if (new_slot) cur = exp_q.pop_front();
      if (u == abort_u) begin
        rst = 1'b0;
        #1;
        checks++;
        if ({out_ch1, out_ch2, slot_cnt, row_idx, row_valid, busy, done, wr_err} !== '0) begin
          errors++;
          $display("FAIL async_reset u=%0d got slot=%0d row=%0d rv=%b busy=%b done=%b err=%b exp all zero",
                   u, slot_cnt, row_idx, row_valid, busy, done, wr_err);
        end
        #1 rst = 1'b1;
        exp_wr_err = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL after_abort busy=%b done=%b exp 0 0", busy, done);
        end
        return;
      end
      checks++;
      if (slot_cnt !== 5'(u % SLOT_LEN)) begin
        errors++; $display("FAIL slot_cnt u=%0d got %0d exp %0d", u, slot_cnt, u % SLOT_LEN);
      end
      checks++;
      if (row_idx !== 5'(u / SLOT_LEN)) begin
        errors++; $display("FAIL row_idx u=%0d got %0d exp %0d", u, row_idx, u / SLOT_LEN);
      end
      checks++;
      if (row_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL flags u=%0d got rv=%b busy=%b done=%b exp 1 1 0", u, row_valid, busy, done);
      end
      checks++;
      if ({out_ch2, out_ch1} !== cur) begin
        errors++; $display("FAIL row_data u=%0d got ch1=%h exp ch1=%h", u, out_ch1, cur[223:0]);
      end
      checks++;
      if (wr_err !== exp_wr_err) begin
        errors++; $display("FAIL wr_err u=%0d got %b exp %b", u, wr_err, exp_wr_err);
      end
      // stimulus for the next edge
      if (hold_mode == 1) h = (u == hold_u) && (held < hold_len);
      else if (hold_mode == 2) h = ($urandom_range(0, 5) == 0);
      else h = 1'b0;
      if (h) held++;
      hold = h;
      if (u == restart_u && !fired_restart) begin
        start = 1'b1; fired_restart = 1'b1;
      end
      if (u == bad_wr_u && !fired_bad) begin
        wr_en = 1'b1; wr_ch = 1'($urandom_range(0, 1)); wr_row = 4'($urandom_range(0, ROWS - 1));
        wr_data = rand224(); fired_bad = 1'b1;
      end
      @(posedge clk); #1;
      if (wr_en) exp_wr_err = 1'b1;
      hold = 1'b0; start = 1'b0; wr_en = 1'b0;
      if (!h) u++;
      new_slot = !h && (u % SLOT_LEN == 0);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || row_valid !== 1'b0) begin
      errors++; $display("FAIL done_cycle got done=%b busy=%b rv=%b exp 1 0 0", done, busy, row_valid);
    end
    checks++;
    if (out_ch1 !== '0 || out_ch2 !== '0) begin
      errors++; $display("FAIL done_outputs got ch1=%h exp 0", out_ch1);
    end
    start = start_in_done;
    hold  = start_in_done;
    @(posedge clk); #1;
    start = 1'b0; hold = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || row_valid !== 1'b0) begin
        errors++; $display("FAIL post_done k=%0d got done=%b busy=%b rv=%b exp 0 0 0", k, done, busy, row_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({out_ch1, out_ch2, slot_cnt, row_idx, row_valid, busy, done, wr_err} !== '0) begin
      errors++; $display("FAIL reset_state got rv=%b busy=%b done=%b err=%b slot=%0d exp all zero",
                         row_valid, busy, done, wr_err, slot_cnt);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || row_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got busy=%b rv=%b exp 0 0", busy, row_valid);
    end
  endtask

  task automatic test_pattern_frame();
    for (int r = 0; r < ROWS; r++) begin
      write_row(1'b0, r, {14{16'(16'h0100 + r)}});
      write_row(1'b1, r, {14{16'(16'h0200 + r)}});
    end
    checks++;
    if (wr_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_writes got err=%b busy=%b exp 0 0", wr_err, busy);
    end
    run_frame(0, -1, 0, -1, 1'b0, -1, -1);
  endtask

  task automatic test_hold();
    run_frame(1, (PAD + 3) * SLOT_LEN + 25, 5, -1, 1'b0, -1, -1);
  endtask

  task automatic test_wr_err();
    write_row(1'b0, 14, rand224());
    checks++;
    if (wr_err !== 1'b1) begin
      errors++; $display("FAIL wr_err_row14 got %b exp 1", wr_err);
    end
    run_frame(0, -1, 0, -1, 1'b0, 100, -1);
    checks++;
    if (wr_err !== 1'b1) begin
      errors++; $display("FAIL wr_err_sticky got %b exp 1", wr_err);
    end
  endtask

  task automatic test_start_ignored();
    run_frame(0, -1, 0, 5 * SLOT_LEN + 3, 1'b1, -1, -1);
  endtask

  task automatic test_reset_mid();
    run_frame(0, -1, 0, -1, 1'b0, -1, (PAD + 7) * SLOT_LEN + 10);
    run_frame(0, -1, 0, -1, 1'b0, -1, -1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < ROWS; r++) begin
        write_row(1'b0, r, rand224());
        write_row(1'b1, r, rand224());
      end
      run_frame(2, -1, 0, $urandom_range(1, FRAME_CYC - 2), 1'b1, -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_pattern_frame();
    test_hold();
    test_wr_err();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv2_row_feeder.md
CONV2_ROW_FEEDER -- requirements
Module: conv2_row_feeder

Interface
REQ-001 Parameter: SLOT_LEN, default 26, cycles per row slot (slot_cnt runs 0..SLOT_LEN-1).
REQ-002 Parameter: ROWS, default 14, data rows per frame per channel.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  frame-buffer write strobe.
REQ-006 wr_ch  input  1  write channel select: 0 = channel 1, 1 = channel 2.
REQ-007 wr_row  input  4  write row index, 0..ROWS-1.
REQ-008 wr_data  input  224  14 x 16-bit pixels; pixel k occupies bits [16k+15:16k].
REQ-009 start  input  1  single-cycle request to stream the stored frame.
REQ-010 hold  input  1  stall; freezes streaming state and outputs.
REQ-011 out_ch1  output  224  channel-1 row feeding the conv stage.
REQ-012 out_ch2  output  224  channel-2 row feeding the conv stage.
REQ-013 slot_cnt  output  5  cycle position within current slot.
REQ-014 row_idx  output  5  current slot number within frame.
REQ-015 row_valid  output  1  high while a slot (data or pad) is presented.
REQ-016 busy  output  1  high from start acceptance until DONE.
REQ-017 done  output  1  one-cycle pulse after last slot.
REQ-018 wr_err  output  1  sticky error flag.

Function
REQ-019 Buffer: 2 x ROWS x 224-bit storage; write when wr_en=1 and busy=0 and wr_row<ROWS.
REQ-020 wr_en with busy=1 or wr_row>=ROWS: write dropped, wr_err set next cycle; wr_err cleared only by accepted start or reset.
REQ-021 FSM states: IDLE, PAD_TOP, STREAM, PAD_BOT, DONE.
REQ-022 IDLE -> PAD_TOP on start=1; busy rises same edge; slot_cnt=0, row_idx=0.
REQ-023 start while busy=1 ignored, no error.
REQ-024 Each slot lasts exactly SLOT_LEN unstalled cycles; slot_cnt increments per unstalled cycle, wraps SLOT_LEN-1 -> 0 and advances row_idx.
REQ-025 PAD_TOP: one slot, out_ch1=out_ch2=0; then STREAM.
REQ-026 STREAM: ROWS slots; slot r drives out_ch1=ch1 row r, out_ch2=ch2 row r, held constant whole slot; after row ROWS-1 -> PAD_BOT.
REQ-027 PAD_BOT: one slot of zeros; then DONE.
REQ-028 DONE: done=1, row_valid=0, busy=0 for one cycle; then IDLE; start in DONE cycle ignored.
REQ-029 row_valid=1 in PAD_TOP, STREAM, PAD_BOT; 0 in IDLE and DONE.
REQ-030 Outputs registered; row data appears the cycle slot_cnt becomes 0 (zero latency relative to slot_cnt).
REQ-031 hold=1 in streaming states: slot_cnt, row_idx, state, outputs unchanged; row_valid stays 1; hold ignored in IDLE/DONE.
REQ-032 hold and slot wrap simultaneous: hold wins, no advance.
REQ-033 Outside STREAM out_ch1/out_ch2 = 0.

Reset
REQ-034 rst=0: state IDLE; out_ch1, out_ch2, slot_cnt, row_idx, row_valid, busy, done, wr_err all 0, asynchronously.
REQ-035 Frame buffer contents not reset; reset mid-frame aborts streaming, no done pulse.

Configuration
REQ-036 Macro ROW_ZERO_PAD_EN: defined -> PAD_TOP and PAD_BOT present, frame = ROWS+2 slots (416 cycles at defaults).
REQ-037 Undefined -> IDLE goes directly to STREAM, STREAM's last slot goes directly to DONE, frame = ROWS slots (364 cycles); all other behaviour identical.

Verification
REQ-038 Write ch1 row r = 16'h0100+r per pixel, ch2 = 16'h0200+r; start, hold=0 -> zero slot, then row 0 (0x0100/0x0200) at cycle 26 after start, row 13 at cycle 364, done at cycle 416 (PAD_EN defined).
REQ-039 Same frame, macro undefined -> row 0 at cycle 0, done pulse at cycle 364, no zero slots.
REQ-040 hold=1 for 5 cycles at slot_cnt=25 of row 3 -> slot_cnt stays 25, out_ch1 stays row 3, done delayed by 5 cycles.
REQ-041 wr_en during busy, and wr_row=14 while idle -> buffer unchanged, wr_err=1 until next start.
REQ-042 rst low at row 7 slot_cnt 10 -> all outputs 0 immediately; subsequent start replays original stored frame from row 0.
REQ-043 start asserted at slot 5 of a running frame and in DONE cycle -> ignored, single done pulse, frame timing unchanged.
